// File: rtl/boot_inst_loader_pkg.sv
// ---------------------------------------------------------------------------
// boot_inst_loader_pkg
// Shared definitions for the boot-time instruction loader:
//   - load_state_t : loader FSM state encodings (3-bit)
//   - CSUM_WIDTH   : width of the XOR checksum carried at the end of a packet
//   - LOAD_TIMEOUT : default idle-cycle limit before a partial packet is dropped
//   - INST_ADDR_W / INST_W / CHIP_ENABLE : OpenMIPS fetch bus definitions
//   - loader_accepting() : which states take stream bytes
// ---------------------------------------------------------------------------
package boot_inst_loader_pkg;

   typedef enum logic [2:0] {
      S_LEN_HI = 3'd0,
      S_LEN_LO = 3'd1,
      S_DATA   = 3'd2,
      S_CSUM   = 3'd3,
      S_DONE   = 3'd4,
      S_ERR    = 3'd5
   } load_state_t;

   localparam int   CSUM_WIDTH   = 8;
   localparam int   LOAD_TIMEOUT = 1000000;

   localparam int   INST_ADDR_W  = 32;
   localparam int   INST_W       = 32;
   localparam logic CHIP_ENABLE  = 1'b1;

   // The loader takes bytes in every state that is still building a packet;
   // the two terminal states refuse further input until reset.
   function automatic logic loader_accepting(input load_state_t st);
      return (st == S_LEN_HI) || (st == S_LEN_LO) ||
             (st == S_DATA)   || (st == S_CSUM);
   endfunction

endpackage

// File: rtl/boot_inst_loader_inst_ram.sv
// ---------------------------------------------------------------------------
// inst_ram
// 2^DEPTH_LOG2 x 32-bit instruction RAM.
//   clk   : write clock
//   we    : write enable (synchronous)
//   waddr : write word index
//   wdata : write data
//   raddr : read word index
//   rdata : read data, asynchronous (combinational from raddr)
// Contents are deliberately not reset.
// ---------------------------------------------------------------------------
module inst_ram #(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] waddr,
   input  logic [31:0]           wdata,
   input  logic [DEPTH_LOG2-1:0] raddr,
   output logic [31:0]           rdata
);

   logic [31:0] mem [0:(2**DEPTH_LOG2)-1];

   // Single synchronous write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Asynchronous read so fetches see data with zero latency
   assign rdata = mem[raddr];

endmodule

// File: rtl/boot_inst_loader.sv
// ---------------------------------------------------------------------------
// boot_inst_loader
// Instruction memory filled at power-up from a byte stream. Packet format:
//   LEN_HI, LEN_LO (word count N, big-endian), 4*N data bytes (big-endian
//   words), then one checksum byte = XOR of all data bytes.
// The CPU is held in reset until a complete, verified image is in RAM.
// Ports:
//   clk          : system clock
//   rst          : asynchronous active-low reset
//   byte_valid_i : stream byte present
//   byte_data_i  : stream byte
//   byte_ready_o : loader accepts a byte this cycle (combinational)
//   ce           : fetch chip enable from OpenMIPS
//   addr         : fetch byte address
//   inst         : fetched instruction (0 unless enabled and loaded)
//   cpu_rst_o    : active-high reset to OpenMIPS
//   load_done_o  : image loaded and verified
//   load_err_o   : load failed, sticky until rst
// ---------------------------------------------------------------------------
module boot_inst_loader
   import boot_inst_loader_pkg::*;
#(
   parameter int DEPTH_LOG2     = 10,
   parameter int TIMEOUT_CYCLES = LOAD_TIMEOUT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   byte_valid_i,
   input  logic [7:0]             byte_data_i,
   output logic                   byte_ready_o,
   input  logic                   ce,
   input  logic [INST_ADDR_W-1:0] addr,
   output logic [INST_W-1:0]      inst,
   output logic                   cpu_rst_o,
   output logic                   load_done_o,
   output logic                   load_err_o
);

   localparam logic [16:0] MAX_WORDS = 17'(2 ** DEPTH_LOG2);
   localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);

   load_state_t           state;
   logic [7:0]            len_hi;
   logic [15:0]           len;
   logic [15:0]           word_cnt;
   logic [1:0]            byte_cnt;
   logic [23:0]           asm_word;
   logic [CSUM_WIDTH-1:0] checksum;
   logic [31:0]           to_cnt;

   logic                  accept;
   logic [15:0]           len_n;
   logic                  len_bad;
   logic                  word_done;
   logic                  timed_out;
   logic [31:0]           ram_wdata;
   logic [31:0]           ram_rdata;
   logic                  unused_addr_bits;

   // Ready is purely a function of state, forced low while reset is held
   assign byte_ready_o = rst && loader_accepting(state);
   assign accept       = byte_valid_i && byte_ready_o;

   // Length as it will be once the low byte lands; checked on that same edge
   assign len_n   = {len_hi, byte_data_i};
   assign len_bad = (len_n == 16'd0) || ({1'b0, len_n} > MAX_WORDS);

   // Only the first three bytes of a word are stored; the fourth goes
   // straight into the RAM write on the edge that accepts it.
   assign word_done = accept && (state == S_DATA) && (byte_cnt == 2'd3);
   assign ram_wdata = {asm_word, byte_data_i};

   // Fires on the idle cycle that would bring the counter to the limit
   assign timed_out = (TIMEOUT_CYCLES != 0) && !accept &&
                      ((state == S_LEN_LO) || (state == S_DATA) ||
                       (state == S_CSUM)) &&
                      (to_cnt == TO_LAST);

   // Loader FSM with byte assembly, checksum, timeout and registered status
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_LEN_HI;
         len_hi      <= 8'd0;
         len         <= 16'd0;
         word_cnt    <= 16'd0;
         byte_cnt    <= 2'd0;
         asm_word    <= 24'd0;
         checksum    <= '0;
         to_cnt      <= 32'd0;
         cpu_rst_o   <= 1'b1;
         load_done_o <= 1'b0;
         load_err_o  <= 1'b0;
      end else begin
         case (state)
            S_LEN_HI: begin
               to_cnt <= 32'd0;
               if (accept) begin
                  len_hi <= byte_data_i;
                  state  <= S_LEN_LO;
               end
            end
            S_LEN_LO, S_DATA, S_CSUM: begin
               if (accept) begin
                  to_cnt <= 32'd0;
                  if (state == S_LEN_LO) begin
                     len      <= len_n;
                     word_cnt <= 16'd0;
                     byte_cnt <= 2'd0;
                     checksum <= '0;
                     if (len_bad) begin
                        state      <= S_ERR;
                        load_err_o <= 1'b1;
                     end else begin
                        state <= S_DATA;
                     end
                  end else if (state == S_DATA) begin
                     asm_word <= {asm_word[15:0], byte_data_i};
                     checksum <= checksum ^ byte_data_i;
                     byte_cnt <= byte_cnt + 2'd1;
                     if (byte_cnt == 2'd3) begin
                        word_cnt <= word_cnt + 16'd1;
                        if (word_cnt == len - 16'd1) begin
                           state <= S_CSUM;
                        end
                     end
                  end else begin
                     if (byte_data_i == checksum) begin
                        state       <= S_DONE;
                        cpu_rst_o   <= 1'b0;
                        load_done_o <= 1'b1;
                     end else begin
                        state      <= S_ERR;
                        load_err_o <= 1'b1;
                     end
                  end
               end else if (timed_out) begin
                  state    <= S_LEN_HI;
                  to_cnt   <= 32'd0;
                  word_cnt <= 16'd0;
                  byte_cnt <= 2'd0;
                  checksum <= '0;
               end else begin
                  to_cnt <= to_cnt + 32'd1;
               end
            end
            S_DONE, S_ERR: begin
               to_cnt <= 32'd0;
            end
            default: begin
               state      <= S_ERR;
               load_err_o <= 1'b1;
            end
         endcase
      end
   end

   inst_ram #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_ram (
      .clk   (clk),
      .we    (word_done),
      .waddr (word_cnt[DEPTH_LOG2-1:0]),
      .wdata (ram_wdata),
      .raddr (addr[DEPTH_LOG2+1:2]),
      .rdata (ram_rdata)
   );

   // Byte-lane bits and bits above the RAM size are don't-cares for fetch
   assign unused_addr_bits = ^{addr[INST_ADDR_W-1:DEPTH_LOG2+2], addr[1:0]};

   // Fetches are gated until the image is verified, so they never race a write
   assign inst = ((ce == CHIP_ENABLE) && !cpu_rst_o) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_boot_inst_loader.sv
// ---------------------------------------------------------------------------
// tb_boot_inst_loader
// Directed testbench for boot_inst_loader. Stimulus pushes expected values
// into a scoreboard queue and raises a probe; a monitor on the falling edge
// pops and compares against the DUT.
// ---------------------------------------------------------------------------
module tb_boot_inst_loader;

   logic        clk;
   logic        rst;
   logic        byte_valid_i;
   logic [7:0]  byte_data_i;
   logic        byte_ready_o;
   logic        ce;
   logic [31:0] addr;
   logic [31:0] inst;
   logic        cpu_rst_o;
   logic        load_done_o;
   logic        load_err_o;

   int          checks = 0;
   int          errors = 0;
   logic        probe  = 1'b0;

   int          kind_q[$];
   logic [31:0] exp_q[$];
   string       name_q[$];

   logic [7:0]  good_stream[11] = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h11, 8'h00,
                                    8'h34, 8'h02, 8'h00, 8'h20, 8'h32};

   boot_inst_loader #(
      .DEPTH_LOG2     (10),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .byte_valid_i (byte_valid_i),
      .byte_data_i  (byte_data_i),
      .byte_ready_o (byte_ready_o),
      .ce           (ce),
      .addr         (addr),
      .inst         (inst),
      .cpu_rst_o    (cpu_rst_o),
      .load_done_o  (load_done_o),
      .load_err_o   (load_err_o)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global watchdog so the run can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Monitor: on each falling edge with a probe raised, pop one expectation
   // and compare it to the DUT output it refers to (status word or inst).
   always @(negedge clk) begin
      if (probe) begin
         logic [31:0] act;
         logic [31:0] expv;
         int          k;
         string       nm;
         checks++;
         if (kind_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty: got probe, required queued expectation");
         end else begin
            k    = kind_q.pop_front();
            expv = exp_q.pop_front();
            nm   = name_q.pop_front();
            if (k == 0) act = {28'd0, cpu_rst_o, load_done_o, load_err_o, byte_ready_o};
            else        act = inst;
            if (act !== expv) begin
               errors++;
               $display("[TB] FAIL %s: got %h, required %h", nm, act, expv);
            end
         end
      end
   end

   // Drive one byte with valid for exactly one rising edge
   task automatic send_byte(input logic [7:0] b);
      byte_valid_i = 1'b1;
      byte_data_i  = b;
      @(posedge clk);
      #1;
      byte_valid_i = 1'b0;
   endtask

   task automatic applyStimulus(input int gaps);
      for (int i = 0; i < 11; i++) begin
         if (gaps != 0) begin
            int g;
            g = $urandom_range(0, 3);
            repeat (g) @(posedge clk);
            #1;
         end
         send_byte(good_stream[i]);
      end
   endtask

   task automatic push_and_probe(input int k, input logic [31:0] e, input string nm);
      kind_q.push_back(k);
      exp_q.push_back(e);
      name_q.push_back(nm);
      probe = 1'b1;
      @(negedge clk);
      #1;
      probe = 1'b0;
   endtask

   // Status expectation: {cpu_rst, done, err, ready}
   task automatic checkOutput(input logic [3:0] st, input string nm);
      push_and_probe(0, {28'd0, st}, nm);
   endtask

   task automatic checkFetch(input logic [31:0] a, input logic [31:0] e, input string nm);
      ce   = 1'b1;
      addr = a;
      push_and_probe(1, e, nm);
      ce   = 1'b0;
   endtask

   task automatic do_reset(input string nm);
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput(4'b1000, nm);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      rst          = 1'b1;
      byte_valid_i = 1'b0;
      byte_data_i  = 8'h00;
      ce           = 1'b0;
      addr         = 32'h0;
      #2;
      rst = 1'b0;
      checkOutput(4'b1000, "reset_state");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      checkOutput(4'b1001, "ready_after_reset");

      // Valid load, one byte per cycle
      for (int i = 0; i < 10; i++) send_byte(good_stream[i]);
      checkOutput(4'b1001, "before_csum");
      send_byte(good_stream[10]);
      checkOutput(4'b0100, "done_on_csum_edge");
      checkFetch(32'h4,    32'h34020020, "fetch_addr4");
      checkFetch(32'h0,    32'h34011100, "fetch_addr0");
      checkFetch(32'h1004, 32'h34020020, "fetch_wrap");
      checkFetch(32'h6,    32'h34020020, "fetch_lowbits_ignored");
      addr = 32'h4;
      push_and_probe(1, 32'h0, "fetch_ce_low");

      // Bytes offered in S_DONE are ignored
      for (int i = 0; i < 6; i++) send_byte(8'hFF);
      checkOutput(4'b0100, "done_ignores_bytes");
      checkFetch(32'h0, 32'h34011100, "ram_unchanged_in_done");

      // Bad checksum
      do_reset("reset_before_badcsum");
      for (int i = 0; i < 10; i++) send_byte(good_stream[i]);
      send_byte(8'h33);
      checkOutput(4'b1010, "bad_csum_err");
      checkFetch(32'h0, 32'h0, "bad_csum_fetch_gated");

      // Zero length
      do_reset("reset_before_len0");
      send_byte(8'h00);
      send_byte(8'h00);
      checkOutput(4'b1010, "len_zero_err");

      // Length one past capacity
      do_reset("reset_before_len1025");
      send_byte(8'h04);
      send_byte(8'h01);
      checkOutput(4'b1010, "len_1025_err");

      // Length exactly at capacity is accepted
      do_reset("reset_before_len1024");
      send_byte(8'h04);
      send_byte(8'h00);
      checkOutput(4'b1001, "len_1024_ok");

      // Idle one cycle short of the timeout keeps the packet alive
      do_reset("reset_before_idle15");
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'hAA);
      repeat (15) @(posedge clk);
      #1;
      send_byte(8'hBB);
      send_byte(8'hCC);
      send_byte(8'hDD);
      send_byte(8'h00);
      checkOutput(4'b0100, "idle15_done");
      checkFetch(32'h0, 32'hAABBCCDD, "idle15_word0");
      checkFetch(32'h4, 32'h34020020, "bad_len_no_write_word1");

      // Full timeout drops the partial packet
      do_reset("reset_before_timeout");
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'hAA);
      send_byte(8'hBB);
      repeat (16) @(posedge clk);
      #1;
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h12);
      send_byte(8'h34);
      send_byte(8'h56);
      send_byte(8'h78);
      send_byte(8'h08);
      checkOutput(4'b0100, "timeout_then_done");
      checkFetch(32'h0, 32'h12345678, "timeout_word0");
      checkFetch(32'h4, 32'h34020020, "timeout_word1_kept");

      // Reset in the middle of a load
      do_reset("reset_before_midload");
      for (int i = 0; i < 5; i++) send_byte(good_stream[i]);
      rst = 1'b0;
      checkOutput(4'b1000, "midload_reset_values");
      checkFetch(32'h0, 32'h0, "midload_fetch_zero");
      @(posedge clk);
      #1;
      rst = 1'b1;
      applyStimulus(0);
      checkOutput(4'b0100, "after_midload_done");
      checkFetch(32'h0, 32'h34011100, "after_midload_word0");

      // Random gaps between bytes
      do_reset("reset_before_gaps");
      applyStimulus(1);
      checkOutput(4'b0100, "gaps_done");
      checkFetch(32'h0, 32'h34011100, "gaps_word0");
      checkFetch(32'h4, 32'h34020020, "gaps_word1");

      @(negedge clk);
      if (kind_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", kind_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
